// File: rtl/ofm_reader.sv
// Output feature-map drain: reads num_words 64-bit words from the output buffer and streams four 16-bit lanes per word.
// Latency: 3 cycles from accepted start to first out_valid; 6 cycles per word when the consumer never stalls.
// Backpressure: out_valid/out_data/out_last hold while out_ready is low; the FSM and address stay frozen.
module ofm_reader #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 64,
    parameter int LANE_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] num_words,
    output logic              busy,
    output logic              done,
    output logic              mem_ena,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_EMIT,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   remain_q;
    logic [DATA_W-1:0]   word_q;
    logic [1:0]          lane_q;

    logic                busy_q;
    logic                done_q;
    logic                mem_ena_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                out_valid_q;
    logic [LANE_W-1:0]   out_data_q;
    logic                out_last_q;

    logic [ADDR_W-1:0]   addr_d;
    logic [ADDR_W-1:0]   remain_d;
    logic [1:0]          lane_d;
    logic                last_word;
    logic                xfer;

    // Lane 0 is the most significant slice, matching the packing order of the conv datapath.
    function automatic logic [LANE_W-1:0] lane_sel(input logic [DATA_W-1:0] w, input logic [1:0] l);
        logic [LANE_W-1:0] r;
        case (l)
            2'd0:    r = w[4*LANE_W-1 -: LANE_W];
            2'd1:    r = w[3*LANE_W-1 -: LANE_W];
            2'd2:    r = w[2*LANE_W-1 -: LANE_W];
            default: r = w[LANE_W-1 -: LANE_W];
        endcase
        return r;
    endfunction

    // Address wraps modulo 2^ADDR_W naturally through the fixed-width add.
    assign addr_d    = addr_q + ADDR_W'(1);
    assign remain_d  = remain_q - ADDR_W'(1);
    assign lane_d    = lane_q + 2'd1;
    assign last_word = (remain_q == ADDR_W'(1));
    assign xfer      = out_valid_q && out_ready;

    // Single FSM process: all outputs are registered so nothing downstream sees a path from out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            word_q      <= '0;
            lane_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_ena_q   <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        busy_q <= 1'b1;
                        if (num_words != '0) begin
                            addr_q     <= base_addr;
                            remain_q   <= num_words;
                            mem_ena_q  <= 1'b1;
                            mem_addr_q <= base_addr;
                            state_q    <= S_FETCH;
                        end else begin
                            // Empty transfer: report completion without touching the buffer.
                            done_q  <= 1'b1;
                            state_q <= S_DONE;
                        end
                    end
                end
                S_FETCH: begin
                    // Read data appears on mem_dout during LATCH.
                    mem_ena_q <= 1'b0;
                    state_q   <= S_LATCH;
                end
                S_LATCH: begin
                    word_q      <= mem_dout;
                    lane_q      <= 2'd0;
                    out_valid_q <= 1'b1;
                    out_data_q  <= lane_sel(mem_dout, 2'd0);
                    out_last_q  <= 1'b0;
                    state_q     <= S_EMIT;
                end
                S_EMIT: begin
                    if (xfer) begin
                        lane_q <= lane_d;
                        if (lane_q == 2'd3) begin
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            remain_q    <= remain_d;
                            addr_q      <= addr_d;
                            if (last_word) begin
                                done_q  <= 1'b1;
                                state_q <= S_DONE;
                            end else begin
                                mem_ena_q  <= 1'b1;
                                mem_addr_q <= addr_d;
                                state_q    <= S_FETCH;
                            end
                        end else begin
                            out_data_q <= lane_sel(word_q, lane_d);
                            out_last_q <= (lane_d == 2'd3) && last_word;
                        end
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign mem_ena   = mem_ena_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

endmodule
